// File: rtl/pktunit_port_monitor.sv
// Passive per-port monitor for the split data/eop packet-unit streams: framing, saturating stats, error pulses.
// Optional build macro PKTMON_CLR_ON_READ_EN makes reads of statistics counters (sel 0-4) clear-on-read.
module pktunit_port_monitor #(
    parameter int NUM_PORTS     = 3,
    parameter int DATA_BYTES    = 8,
    parameter int MIN_PKT_BYTES = 60,
    parameter int MAX_PKT_BYTES = 1518
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            data_v,
    input  logic [NUM_PORTS-1:0]            data_r,
    input  logic [NUM_PORTS*DATA_BYTES-1:0] eop_d,
    input  logic [NUM_PORTS-1:0]            eop_v,
    input  logic [NUM_PORTS-1:0]            eop_r,
    input  logic                            rd_en,
    input  logic [3:0]                      rd_port,
    input  logic [2:0]                      rd_sel,
    output logic [31:0]                     rd_data,
    output logic                            rd_valid,
    output logic [NUM_PORTS-1:0]            err_pulse
);

    typedef enum logic {S_IDLE = 1'b0, S_IN_PKT = 1'b1} state_t;

    localparam logic [16:0] MIN_L = 17'(MIN_PKT_BYTES);
    localparam logic [16:0] MAX_L = 17'(MAX_PKT_BYTES);

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    logic [NUM_PORTS*32-1:0] pkts_bus, bytes_bus, runt_bus, over_bus, perr_bus;
    logic [NUM_PORTS*16-1:0] cur_bus;
    logic [NUM_PORTS-1:0]    state_bus;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        state_t                state_q, state_d;
        logic [15:0]           cur_len_q, cur_len_d;
        logic [31:0]           pkts_q, pkts_d, bytes_q, bytes_d;
        logic [31:0]           runt_q, runt_d, over_q, over_d, perr_q, perr_d;
        logic                  err_q, err_d;
        logic [DATA_BYTES-1:0] eop_s, eop_m1;
        logic                  dh, eh, accept, is_last, one_hot;
        logic                  pkt_close, runt_inc, over_inc, perr_inc;
        logic [6:0]            beat_bytes;
        logic [16:0]           len_sum;
        logic [15:0]           len_sat;
        logic [4:0]            clr;

        always_comb begin
            eop_s   = eop_d[p*DATA_BYTES +: DATA_BYTES];
            eop_m1  = eop_s - DATA_BYTES'(1);
            dh      = data_v[p] & data_r[p];
            eh      = eop_v[p] & eop_r[p];
            accept  = dh & eh;
            is_last = |eop_s;
            one_hot = is_last && ((eop_s & eop_m1) == '0);

            beat_bytes = 7'(DATA_BYTES);
            if (one_hot) begin
                for (int k = 0; k < DATA_BYTES; k++) begin
                    if (eop_s[k]) beat_bytes = 7'(k + 1);
                end
            end

            // Running length including this beat; idle ports start from zero.
            len_sum = 17'(beat_bytes) + ((state_q == S_IN_PKT) ? {1'b0, cur_len_q} : 17'd0);
            len_sat = len_sum[16] ? 16'hFFFF : len_sum[15:0];

            pkt_close = accept & is_last;
            runt_inc  = pkt_close & ({1'b0, len_sat} < MIN_L);
            over_inc  = pkt_close & ({1'b0, len_sat} > MAX_L);
            perr_inc  = (dh ^ eh) | (pkt_close & ~one_hot);

            clr = '0;
`ifdef PKTMON_CLR_ON_READ_EN
            for (int s = 0; s < 5; s++) begin
                clr[s] = rd_en && (rd_port == 4'(p)) && (rd_sel == 3'(s));
            end
`endif

            state_d   = state_q;
            cur_len_d = cur_len_q;
            if (accept) begin
                if (is_last) begin
                    state_d   = S_IDLE;
                    cur_len_d = '0;
                end else begin
                    state_d   = S_IN_PKT;
                    cur_len_d = len_sat;
                end
            end

            pkts_d  = sat_add(clr[0] ? 32'd0 : pkts_q,  {31'd0, pkt_close});
            bytes_d = sat_add(clr[1] ? 32'd0 : bytes_q, pkt_close ? {16'd0, len_sat} : 32'd0);
            runt_d  = sat_add(clr[2] ? 32'd0 : runt_q,  {31'd0, runt_inc});
            over_d  = sat_add(clr[3] ? 32'd0 : over_q,  {31'd0, over_inc});
            perr_d  = sat_add(clr[4] ? 32'd0 : perr_q,  {31'd0, perr_inc});
            err_d   = perr_inc | runt_inc | over_inc;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q   <= S_IDLE;
                cur_len_q <= '0;
                pkts_q    <= '0;
                bytes_q   <= '0;
                runt_q    <= '0;
                over_q    <= '0;
                perr_q    <= '0;
                err_q     <= 1'b0;
            end else begin
                state_q   <= state_d;
                cur_len_q <= cur_len_d;
                pkts_q    <= pkts_d;
                bytes_q   <= bytes_d;
                runt_q    <= runt_d;
                over_q    <= over_d;
                perr_q    <= perr_d;
                err_q     <= err_d;
            end
        end

        assign pkts_bus[p*32 +: 32]  = pkts_q;
        assign bytes_bus[p*32 +: 32] = bytes_q;
        assign runt_bus[p*32 +: 32]  = runt_q;
        assign over_bus[p*32 +: 32]  = over_q;
        assign perr_bus[p*32 +: 32]  = perr_q;
        assign cur_bus[p*16 +: 16]   = cur_len_q;
        assign state_bus[p]          = (state_q == S_IN_PKT);
        assign err_pulse[p]          = err_q;
    end

    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;

    // Out-of-range ports match no loop index and therefore read as zero.
    always_comb begin
        rd_valid_d = rd_en;
        rd_data_d  = rd_data_q;
        if (rd_en) begin
            rd_data_d = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (rd_port == 4'(p)) begin
                    case (rd_sel)
                        3'd0:    rd_data_d = pkts_bus[p*32 +: 32];
                        3'd1:    rd_data_d = bytes_bus[p*32 +: 32];
                        3'd2:    rd_data_d = runt_bus[p*32 +: 32];
                        3'd3:    rd_data_d = over_bus[p*32 +: 32];
                        3'd4:    rd_data_d = perr_bus[p*32 +: 32];
                        3'd5:    rd_data_d = {16'd0, cur_bus[p*16 +: 16]};
                        3'd6:    rd_data_d = {31'd0, state_bus[p]};
                        default: rd_data_d = '0;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_pktunit_port_monitor.sv
// Scoreboarded bench for pktunit_port_monitor: register reads are queued with expected values and checked on rd_valid.
module tb_pktunit_port_monitor;
  localparam int NP = 3;
  localparam int DB = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP-1:0]    data_v, data_r, eop_v, eop_r;
  logic [NP*DB-1:0] eop_d;
  logic             rd_en;
  logic [3:0]       rd_port;
  logic [2:0]       rd_sel;
  logic [31:0]      rd_data;
  logic             rd_valid;
  logic [NP-1:0]    err_pulse;

  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [31:0] mon_exp;
  string       mon_name;

  pktunit_port_monitor #(
    .NUM_PORTS(NP), .DATA_BYTES(DB), .MIN_PKT_BYTES(60), .MAX_PKT_BYTES(1518)
  ) dut (
    .clk(clk), .rst(rst),
    .data_v(data_v), .data_r(data_r), .eop_d(eop_d), .eop_v(eop_v), .eop_r(eop_r),
    .rd_en(rd_en), .rd_port(rd_port), .rd_sel(rd_sel),
    .rd_data(rd_data), .rd_valid(rd_valid), .err_pulse(err_pulse)
  );

  // clock / reset / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard: every rd_valid pops one expected read result
  always @(negedge clk) begin
    if (rd_valid) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_rd_valid: rd_data=%0d with no read outstanding", rd_data);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        if (rd_data !== mon_exp) begin
          mismatched++;
          $display("FAIL %s: rd_data=%0d expected %0d", mon_name, rd_data, mon_exp);
        end
      end
    end
  end

  // driver tasks: inputs change only at negedges and are held across one posedge
  task automatic step(input logic [NP-1:0] dv, input logic [NP-1:0] dr,
                      input logic [NP-1:0] ev, input logic [NP-1:0] er,
                      input logic [NP*DB-1:0] ed);
    data_v = dv; data_r = dr; eop_v = ev; eop_r = er; eop_d = ed;
    @(negedge clk);
    data_v = '0; data_r = '0; eop_v = '0; eop_r = '0; eop_d = '0;
    rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, '0, '0, '0, '0);
  endtask

  task automatic beat(input int p, input logic [DB-1:0] ed);
    logic [NP-1:0]    m;
    logic [NP*DB-1:0] e;
    m = '0; m[p] = 1'b1;
    e = '0; e[p*DB +: DB] = ed;
    step(m, m, m, m, e);
  endtask

  task automatic rd_issue(input int p, input int s, input logic [31:0] e, input string n);
    rd_en = 1'b1; rd_port = 4'(p); rd_sel = 3'(s);
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic read(input int p, input int s, input logic [31:0] e, input string n);
    rd_issue(p, s, e, n);
    idle(1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    compared++;
    if (rd_valid !== 1'b0) begin
      mismatched++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid);
    end
    compared++;
    if (err_pulse !== '0) begin
      mismatched++; $display("FAIL reset_err_pulse: got %b expected 000", err_pulse);
    end
    rst = 1'b0;
    for (int p = 0; p < NP; p++)
      for (int s = 0; s < 7; s++)
        read(p, s, 32'd0, $sformatf("reset_p%0d_sel%0d", p, s));
  endtask

  task automatic test_basic_port0();
    repeat (4) beat(0, 8'h00);
    read(0, 5, 32'd32, "p0_cur_len_mid");
    read(0, 6, 32'd1,  "p0_state_mid");
    repeat (4) beat(0, 8'h00);
    beat(0, 8'h08);
    read(0, 0, 32'd1,  "p0_pkts");
    read(0, 1, 32'd68, "p0_bytes");
    read(0, 2, 32'd0,  "p0_runt");
    read(0, 3, 32'd0,  "p0_oversize");
    read(0, 5, 32'd0,  "p0_cur_len_end");
    read(0, 6, 32'd0,  "p0_state_end");
  endtask

  task automatic test_runt_port1();
    beat(1, 8'h01);
    compared++;
    if (err_pulse !== 3'b010) begin
      mismatched++; $display("FAIL runt_err_pulse_high: got %b expected 010", err_pulse);
    end
    idle(1);
    compared++;
    if (err_pulse !== 3'b000) begin
      mismatched++; $display("FAIL runt_err_pulse_low: got %b expected 000", err_pulse);
    end
    read(1, 0, 32'd1, "p1_pkts");
    read(1, 1, 32'd1, "p1_bytes");
    read(1, 2, 32'd1, "p1_runt");
    read(0, 0, 32'd1, "p0_pkts_untouched");
  endtask

  task automatic test_oversize_port2();
    repeat (190) beat(2, 8'h00);
    beat(2, 8'h80);
    compared++;
    if (err_pulse !== 3'b100) begin
      mismatched++; $display("FAIL oversize_err_pulse: got %b expected 100", err_pulse);
    end
    read(2, 3, 32'd1,    "p2_oversize");
    read(2, 1, 32'd1528, "p2_bytes");
    read(2, 0, 32'd1,    "p2_pkts");
    read(2, 2, 32'd0,    "p2_runt");
    repeat (5) beat(2, 8'h00);
    read(2, 5, 32'd40, "p2_cur_len_partial");
    pulse_reset();
    for (int s = 0; s < 7; s++)
      read(2, s, 32'd0, $sformatf("p2_after_reset_sel%0d", s));
    read(0, 0, 32'd0, "p0_pkts_after_reset");
  endtask

  task automatic test_proto_port0();
    repeat (3) step(3'b001, 3'b001, 3'b000, 3'b000, '0);
    compared++;
    if (err_pulse !== 3'b001) begin
      mismatched++; $display("FAIL proto_err_pulse: got %b expected 001", err_pulse);
    end
    read(0, 4, 32'd3, "p0_proto_3");
    read(0, 0, 32'd0, "p0_pkts_no_beat");
    read(0, 6, 32'd0, "p0_state_no_beat");
    beat(0, 8'h11);
    read(0, 4, 32'd4, "p0_proto_4");
    read(0, 0, 32'd1, "p0_pkts_bad_eop");
    read(0, 1, 32'd8, "p0_bytes_bad_eop");
    read(0, 2, 32'd1, "p0_runt_bad_eop");
  endtask

  task automatic test_read_bounds();
    rd_issue(5, 0, 32'd0, "port5_read");
    idle(1);
    compared++;
    if (rd_valid !== 1'b1) begin
      mismatched++; $display("FAIL port5_rd_valid: got %b expected 1", rd_valid);
    end
    read(0, 7, 32'd0,  "sel7_read");
    read(15, 1, 32'd0, "port15_read");
  endtask

  task automatic test_clr_on_read();
    rd_issue(0, 0, 32'd1, "p0_pkts_coincident");
    beat(0, 8'h80);
`ifdef PKTMON_CLR_ON_READ_EN
    read(0, 0, 32'd1, "p0_pkts_after_clear");
`else
    read(0, 0, 32'd2, "p0_pkts_no_clear");
`endif
    read(0, 1, 32'd16, "p0_bytes_not_cleared");
  endtask

  task automatic test_random_len();
    int n, k, len, pk, by, ru;
    pulse_reset();
    pk = 0; by = 0; ru = 0;
    for (int i = 0; i < 4; i++) begin
      n = $urandom_range(0, 9);
      k = $urandom_range(0, 7);
      repeat (n) beat(1, 8'h00);
      beat(1, 8'(1 << k));
      len = n * 8 + k + 1;
      pk++; by += len;
      if (len < 60) ru++;
    end
    read(1, 0, 32'(pk), "rand_pkts");
    read(1, 1, 32'(by), "rand_bytes");
    read(1, 2, 32'(ru), "rand_runt");
    read(1, 3, 32'd0,   "rand_oversize");
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    repeat (7) step(3'b111, 3'b111, 3'b111, 3'b111, '0);
    step(3'b111, 3'b111, 3'b111, 3'b111, {8'h80, 8'h80, 8'h80});
    compared++;
    if (err_pulse !== 3'b000) begin
      mismatched++; $display("FAIL b2b_err_pulse: got %b expected 000", err_pulse);
    end
    for (int p = 0; p < NP; p++) begin
      rd_issue(p, 0, 32'd1, $sformatf("b2b_p%0d_pkts", p));
      idle(1);
      rd_issue(p, 1, 32'd64, $sformatf("b2b_p%0d_bytes", p));
      idle(1);
      rd_issue(p, 2, 32'd0, $sformatf("b2b_p%0d_runt", p));
      idle(1);
    end
  endtask

  initial begin
    rst = 1'b1;
    data_v = '0; data_r = '0; eop_v = '0; eop_r = '0; eop_d = '0;
    rd_en = 1'b0; rd_port = '0; rd_sel = '0;
    test_reset();
    test_basic_port0();
    test_runt_port1();
    test_oversize_port2();
    test_proto_port0();
    test_read_bounds();
    test_clr_on_read();
    test_random_len();
    test_back_to_back();
    idle(3);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++; $display("FAIL reads_outstanding: %0d left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
